// File: rtl/usb_pio_pkg.sv
// ============================================================================
// Module   : usb_pio_pkg
// Purpose  : Shared register map and edge-type encodings for usb_int_pio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

`default_nettype wire

// File: rtl/usb_pio_debounce.sv
// ============================================================================
// Module   : usb_pio_debounce
// Purpose  : One-bit 2-flop synchronizer followed by a stable-count debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_din,
  output logic o_stable
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_stable = r_sync;
    end else begin : g_filter
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_stable;

      // Any return to the accepted value restarts the interval from zero.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_stable <= r_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign o_stable = r_stable;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/usb_int_pio.sv
// ============================================================================
// Module   : usb_int_pio
// Purpose  : Avalon-MM input PIO with debounce, sticky edge capture and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_int_pio
  import usb_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      w_rd;
  logic             w_wr;

  assign w_wr = chipselect & ~write_n;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      usb_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .i_din   (in_port[i]),
        .o_stable(w_stable[i])
      );
    end
  endgenerate

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign w_edge = w_stable & ~r_stable_d;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign w_edge = ~w_stable & r_stable_d;
    end else begin : g_any
      assign w_edge = w_stable ^ r_stable_d;
    end
  endgenerate

  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // A newly detected edge overrides a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:    w_rd[WIDTH-1:0] = w_stable;
      ADDR_RSVD:    w_rd = '0;
      ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_edgecap;
      default:      w_rd = '0;
    endcase
  end

  assign readdata = w_rd;
  assign irq      = |(r_edgecap & r_irqmask);

  generate
    if (WIDTH < 32) begin : g_unused
      logic w_unused_wd;
      assign w_unused_wd = |writedata[31:WIDTH];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_usb_int_pio.sv
// ============================================================================
// Module   : tb_usb_int_pio
// Purpose  : Randomized self-checking bench for usb_int_pio against a
//            history-based reference model of the debounced input path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_int_pio;

  localparam int W  = 4;
  localparam int D  = 16;
  localparam int ET = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = '0;
  logic         irq;

  always #5 clk = ~clk;

  usb_int_pio #(
    .WIDTH(W),
    .EDGE_TYPE(ET),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: hist[k] is in_port as sampled at edge k after reset release,
  // st[k] the debounced value after edge k.
  logic [W-1:0] hist [0:8191];
  logic [W-1:0] st   [0:8191];
  int           k = 0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_ecap = '0;

  function automatic logic [W-1:0] h(input int i);
    return (i < 0) ? '0 : hist[i];
  endfunction

  function automatic logic [W-1:0] sa(input int i);
    return (i < 0) ? '0 : st[i];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(sa(k - 1));
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_ecap);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    k      = 0;
    m_mask = '0;
    m_ecap = '0;
  endtask

  // A bit flips once the synchronized line has held the opposite value for
  // D consecutive cycles; the synchronized line lags in_port by one sample.
  task automatic model_edge();
    logic [W-1:0] prev, nxt, sd, sdd, edg, clr, t;
    bit ok;
    hist[k] = in_port;
    prev = sa(k - 1);
    nxt  = prev;
    for (int b = 0; b < W; b++) begin
      ok = 1'b1;
      for (int j = k - D - 1; j <= k - 2; j++) begin
        t = h(j);
        if (t[b] == prev[b]) ok = 1'b0;
      end
      if (ok) nxt[b] = ~prev[b];
    end
    st[k] = nxt;
    sd  = sa(k - 1);
    sdd = sa(k - 2);
    case (ET)
      0:       edg = sd & ~sdd;
      1:       edg = ~sd & sdd;
      default: edg = sd ^ sdd;
    endcase
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ecap = (m_ecap & ~clr) | edg;
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
    check("rd", readdata, exp_rd(address));
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    logic [31:0] v;
    int cnt;
    int hold [W];
    int r;

    // Reset with all inputs low: every register reads zero.
    #2;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check("rst_rd", readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();

    // Falling edge on bit 0: latency to irq and W1C.
    in_port = '1;
    repeat (25) tick();
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    cnt = 0;
    while (irq == 1'b0 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("irq_latency", 32'(cnt), 32'd19);
    rd(2'd3, v);
    check("ecap_bit0", v, 32'h1);
    bus_wr(2'd3, 32'h1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(2'd3, v);
    check("ecap_after_w1c", v, 32'h0);

    // Short glitch on bit 1 is filtered out.
    in_port[1] = 1'b0;
    repeat (10) tick();
    in_port[1] = 1'b1;
    repeat (30) tick();
    rd(2'd0, v);
    check("glitch_data", v, 32'hE);
    rd(2'd3, v);
    check("glitch_ecap", v, 32'h0);

    // Masked capture, then enable the mask.
    bus_wr(2'd2, 32'h0);
    in_port[2] = 1'b0;
    repeat (25) tick();
    rd(2'd3, v);
    check("masked_ecap", v, 32'h4);
    check("masked_irq", {31'd0, irq}, 32'd0);
    bus_wr(2'd2, 32'h4);
    check("unmask_irq", {31'd0, irq}, 32'd1);

    // W1C on bit 3 in the very cycle a new edge is captured.
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'h8);
    in_port[3] = 1'b0;
    repeat (25) tick();
    in_port[3] = 1'b1;
    repeat (25) tick();
    check("bit3_pre_irq", {31'd0, irq}, 32'd1);
    in_port[3] = 1'b0;
    repeat (18) tick();
    bus_wr(2'd3, 32'h8);
    rd(2'd3, v);
    check("setwins_ecap", v, 32'h8);
    check("setwins_irq", {31'd0, irq}, 32'd1);

    // Reset mid-debounce clears everything; full latency afterwards.
    in_port[0] = 1'b1;
    repeat (12) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check("midrst_rd", readdata, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (17) tick();
    rd(2'd0, v);
    check("post_rst_early", v, 32'h0);
    tick();
    rd(2'd0, v);
    check("post_rst_data", v, 32'h3);

    // Randomized traffic on inputs and bus.
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 40);
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          in_port[b] = ~in_port[b];
          hold[b]    = $urandom_range(1, 40);
        end else begin
          hold[b]--;
        end
      end
      r          = $urandom_range(0, 9);
      chipselect = (r < 2);
      write_n    = (r < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_int_pio.md
# usb_int_pio

Avalon-MM slave input port that samples external status/interrupt lines, such as the USB controller's INT# and status pins, into the Nios system. It is the read-side counterpart of the single-bit output PIO that drives the USB controller reset. The block synchronizes and debounces each input and captures edges into a sticky register. It raises a maskable level interrupt to the CPU.

## Interface
Parameters:
- WIDTH, 4: number of input lines, 1..32.
- EDGE_TYPE, 1: captured edge. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a change is accepted. 0 bypasses the debouncer.

Ports:
- clk, input, 1: system clock. The only clock.
- reset_n, input, 1: reset, asynchronous, active-low.
- address, input, 2: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: write strobe, active-low.
- writedata, input, 32: write data.
- readdata, output, 32: read data. Zero wait-state.
- in_port, input, WIDTH: asynchronous external lines.
- irq, output, 1: level interrupt, active-high.

## Operation
Register map. Bits [31:WIDTH] always read 0.
- Address 0, data (RO): debounced input value. Writes are ignored.
- Address 1, reserved: reads 0. Writes are ignored.
- Address 2, irqmask (RW): per-bit interrupt enable.
- Address 3, edgecapture (R/W1C): sticky edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.

Write qualification: a write occurs when chipselect is 1 and write_n is 0. Reads are combinational on address, with read latency 0.

Per-bit input path:
- 2-flop synchronizer produces sync.
- The debouncer holds stable. A counter increments while sync differs from stable and resets to 0 when they match. When the counter reaches DEBOUNCE_CYCLES-1, stable takes sync and the counter resets.
- With DEBOUNCE_CYCLES = 0, stable equals sync.
- stable_d is stable delayed by 1 cycle.
- Edge detect:
  - rising: stable & ~stable_d
  - falling: ~stable & stable_d
  - any: stable ^ stable_d
- edgecapture bit: set on a detected edge, cleared by W1C. If both happen in the same cycle, set wins.
- irq = |(edgecapture & irqmask), computed from registered values only.

Reset values: all of the following are 0: synchronizer, stable, stable_d, counters, irqmask, edgecapture, irq, readdata (address 0).

Reset release with an input held high: stable rises after synchronizer plus debounce latency. In rising or any mode this captures an edge. This is intended; driver init clears edgecapture after enabling the mask.

Reset mid-operation clears all state immediately, including partially counted debounce intervals.

## Timing
- Input change to synchronizer output: 2 clk edges.
- Synchronizer output to stable: DEBOUNCE_CYCLES cycles when held steady. Any glitch back to the old value restarts the count.
- stable change to edgecapture set: 1 cycle. edgecapture to irq: combinational, same cycle.
- Total in_port change to irq high: 2 + DEBOUNCE_CYCLES + 1 clk edges. With the debouncer bypassed, this is 3.
- W1C write at edge N: the bit reads 0 and irq drops after edge N, unless a new edge is detected at edge N.
- irqmask write: takes effect on irq the cycle after the write edge.

## Structure
- Shared package `usb_pio_pkg`:
  - Register address constants ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
  - Edge-type encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module `usb_pio_debounce`: one bit wide, containing the synchronizer, counter and stable register. Parameterized by DEBOUNCE_CYCLES and instantiated WIDTH times via generate.
- The top level holds edge detection, edgecapture, irqmask, the read mux and the irq reduction.

## Test plan
1. Reset with in_port held at 4'b0000, then read all four addresses. Required: every read returns 0 and irq = 0.
2. EDGE_TYPE = 1, DEBOUNCE_CYCLES = 16, irqmask = 4'b0001. Drop in_port[0] from 1 to 0 after it has been stable high.
   - Required: irq rises exactly 19 cycles after the change.
   - Required: edgecapture reads 32'h1.
   - Then write 32'h1 to address 3. Required: irq = 0 on the next cycle and edgecapture reads 0.
3. Glitch in_port[1] low for 10 cycles with DEBOUNCE_CYCLES = 16. Required: data bit 1 never changes and edgecapture bit 1 stays 0.
4. Capture an edge on bit 2 with irqmask = 0.
   - Required: edgecapture = 32'h4 and irq = 0.
   - Then write irqmask = 32'h4. Required: irq = 1 one cycle later.
5. Issue a W1C write of 32'h8 in the same cycle a new edge is detected on bit 3. Required: bit 3 remains set and irq stays high.
6. Assert reset_n low mid-debounce, with the counter at 10. Required:
   - All state clears asynchronously and irq = 0.
   - After release, a stable input change requires the full 2 + 16 cycles before data updates.
